// File: rtl/ram_dp_fifo_ctrl.sv
// First-word-fall-through FIFO controller around a dual-port RAM (write on A, read on B).
// A two-entry output buffer hides the one-cycle RAM read latency so push/pop can run at full rate.
module ram_dp_fifo_ctrl #(
    parameter int Word_Width = 32,
    parameter int Addr_Width = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [Word_Width-1:0] in_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [Word_Width-1:0] out_data_o,
    output logic [Addr_Width+1:0] usedw_o,
    output logic                  cena_o,
    output logic                  wena_o,
    output logic [Addr_Width-1:0] addra_o,
    output logic [Word_Width-1:0] dataa_o,
    output logic                  cenb_o,
    output logic                  wenb_o,
    output logic [Addr_Width-1:0] addrb_o,
    input  logic [Word_Width-1:0] datab_i
);

    localparam logic [Addr_Width:0] DEPTH_C = {1'b1, {Addr_Width{1'b0}}};

    logic [Addr_Width-1:0] wptr;
    logic [Addr_Width-1:0] rptr;
    logic [Addr_Width:0]   mem_cnt;
    logic                  rd_pend;
    logic [1:0]            buf_cnt;
    logic                  in_ready_q;
    logic [Addr_Width+1:0] usedw_q;
    logic [Word_Width-1:0] head;
    logic [Word_Width-1:0] tail;

    logic                  push;
    logic                  pop;
    logic                  rd_go;
    logic                  ret;
    logic [Addr_Width:0]   mem_cnt_nxt;
    logic [1:0]            buf_cnt_nxt;
    logic [1:0]            buf_left;

    // flush suppresses every handshake and RAM access in its cycle
    always_comb begin
        push        = in_valid_i & in_ready_q & ~flush_i;
        pop         = (buf_cnt != 2'd0) & out_ready_i & ~flush_i;
        ret         = rd_pend & ~flush_i;
        rd_go       = ~flush_i & (mem_cnt != '0) &
                      (({1'b0, buf_cnt} + {2'b00, rd_pend}) < (3'd2 + {2'b00, pop}));
        mem_cnt_nxt = mem_cnt + (Addr_Width+1)'(push) - (Addr_Width+1)'(rd_go);
        buf_cnt_nxt = buf_cnt + 2'(ret) - 2'(pop);
        buf_left    = buf_cnt - 2'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr       <= '0;
            rptr       <= '0;
            mem_cnt    <= '0;
            rd_pend    <= 1'b0;
            buf_cnt    <= 2'd0;
            in_ready_q <= 1'b1;
            usedw_q    <= '0;
        end else if (flush_i) begin
            wptr       <= '0;
            rptr       <= '0;
            mem_cnt    <= '0;
            rd_pend    <= 1'b0;
            buf_cnt    <= 2'd0;
            in_ready_q <= 1'b1;
            usedw_q    <= '0;
        end else begin
            wptr       <= wptr + Addr_Width'(push);
            rptr       <= rptr + Addr_Width'(rd_go);
            mem_cnt    <= mem_cnt_nxt;
            rd_pend    <= rd_go;
            buf_cnt    <= buf_cnt_nxt;
            in_ready_q <= (mem_cnt_nxt != DEPTH_C);
            usedw_q    <= {1'b0, mem_cnt_nxt} + (Addr_Width+2)'(rd_go) + (Addr_Width+2)'(buf_cnt_nxt);
        end
    end

    // Returning word lands in the head when the buffer is (or is becoming) empty; the later
    // nonblocking write to head wins over the tail shift in that case.
    always_ff @(posedge clk) begin
        if (pop)
            head <= tail;
        if (ret) begin
            if (buf_left == 2'd0)
                head <= datab_i;
            else
                tail <= datab_i;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign usedw_o     = usedw_q;
    assign out_valid_o = (buf_cnt != 2'd0);
    assign out_data_o  = head;
    assign cena_o      = ~(push & rst_n);
    assign wena_o      = ~(push & rst_n);
    assign addra_o     = wptr;
    assign dataa_o     = in_data_i;
    assign cenb_o      = ~(rd_go & rst_n);
    assign wenb_o      = 1'b1;
    assign addrb_o     = rptr;

endmodule

// File: tb/tb_ram_dp_fifo_ctrl.sv
// Bench for ram_dp_fifo_ctrl with a behavioural RAM and a queue-based FIFO reference model.
`timescale 1ns/1ps
module tb_ram_dp_fifo_ctrl;

    localparam int WW = 32;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [WW-1:0] in_data_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [WW-1:0] out_data_o;
    logic [AW+1:0] usedw_o;
    logic          cena_o, wena_o, cenb_o, wenb_o;
    logic [AW-1:0] addra_o, addrb_o;
    logic [WW-1:0] dataa_o, datab_i;

    int n_vec  = 0;
    int n_fail = 0;

    ram_dp_fifo_ctrl #(.Word_Width(WW), .Addr_Width(AW)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
        .usedw_o(usedw_o),
        .cena_o(cena_o), .wena_o(wena_o), .addra_o(addra_o), .dataa_o(dataa_o),
        .cenb_o(cenb_o), .wenb_o(wenb_o), .addrb_o(addrb_o), .datab_i(datab_i)
    );

    always #5 clk = ~clk;

    // Behavioural dual-port RAM with one-cycle registered read
    logic [WW-1:0] ram [16];
    always @(posedge clk) begin
        if (!cena_o && !wena_o) ram[addra_o] <= dataa_o;
        if (!cenb_o && wenb_o)  datab_i <= ram[addrb_o];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: words accepted and not yet popped, in order
    logic [WW-1:0] q[$];
    int wcnt = 0;
    int rcnt = 0;
    int npop = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_cena", 64'(cena_o), 64'(1));
            chk("rst_cenb", 64'(cenb_o), 64'(1));
            chk("rst_oval", 64'(out_valid_o), 64'(0));
            q.delete();
            wcnt = 0;
            rcnt = 0;
        end else begin
            chk("usedw", 64'(usedw_o), 64'(q.size()));
            chk("cena_rule", 64'(cena_o), 64'(!(in_valid_i && in_ready_o && !flush_i)));
            chk("wena_eq", 64'(wena_o), 64'(cena_o));
            chk("wenb_tied", 64'(wenb_o), 64'(1));
            if (q.size() < 16)  chk("in_ready_free", 64'(in_ready_o), 64'(1));
            if (q.size() >= 18) chk("in_ready_full", 64'(in_ready_o), 64'(0));
            if (out_valid_o) begin
                chk("oval_has_word", 64'(q.size() != 0), 64'(1));
                if (q.size() != 0) chk("head_data", 64'(out_data_o), 64'(q[0]));
            end
            if (flush_i) begin
                chk("flush_cenb", 64'(cenb_o), 64'(1));
                q.delete();
                wcnt = 0;
                rcnt = 0;
            end else begin
                if (!cenb_o) begin
                    chk("rd_addr", 64'(addrb_o), 64'(rcnt % 16));
                    chk("rd_after_wr", 64'(rcnt < wcnt), 64'(1));
                    rcnt++;
                end
                if (!cena_o) begin
                    chk("wr_addr", 64'(addra_o), 64'(wcnt % 16));
                    chk("wr_room", 64'(q.size() < 18), 64'(1));
                    q.push_back(dataa_o);
                    wcnt++;
                end
                if (out_valid_o && out_ready_i && q.size() != 0) begin
                    void'(q.pop_front());
                    npop++;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not reach the end of the directed sequence");
        $fatal(1, "timeout");
    end

    initial begin
        int sent;
        int got;
        int base;
        bit started;

        rst_n = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; in_data_i = '0; out_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: single push shows up after three edges
        @(negedge clk);
        chk("t1_ready", 64'(in_ready_o), 64'(1));
        chk("t1_usedw0", 64'(usedw_o), 64'(0));
        chk("t1_oval0", 64'(out_valid_o), 64'(0));
        @(posedge clk); #1 in_valid_i = 1'b1; in_data_i = 32'h11;
        @(posedge clk); #1 in_valid_i = 1'b0;
        @(negedge clk);
        chk("t1_lat1", 64'(out_valid_o), 64'(0));
        chk("t1_usedw1", 64'(usedw_o), 64'(1));
        @(posedge clk); @(negedge clk);
        chk("t1_lat2", 64'(out_valid_o), 64'(0));
        @(posedge clk); @(negedge clk);
        chk("t1_valid", 64'(out_valid_o), 64'(1));
        chk("t1_data", 64'(out_data_o), 64'(32'h11));
        chk("t1_usedw", 64'(usedw_o), 64'(1));
        @(posedge clk); #1 out_ready_i = 1'b1;
        @(posedge clk); #1 out_ready_i = 1'b0;
        @(negedge clk);
        chk("t1_empty", 64'(out_valid_o), 64'(0));

        // 2: fill to DEPTH+2 with the consumer stalled, then drain in order
        sent = 0;
        @(posedge clk); #1 in_valid_i = 1'b1; in_data_i = 0;
        repeat (30) begin
            @(negedge clk);
            if (in_valid_i && in_ready_o) sent++;
            @(posedge clk); #1 in_data_i = 32'(sent);
        end
        in_valid_i = 1'b0;
        @(negedge clk);
        chk("t2_accepted", 64'(sent), 64'(18));
        chk("t2_usedw", 64'(usedw_o), 64'(18));
        chk("t2_full", 64'(in_ready_o), 64'(0));
        @(posedge clk); #1 out_ready_i = 1'b1;
        got = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid_o) begin
                chk("t2_order", 64'(out_data_o), 64'(got));
                got++;
            end
            @(posedge clk); #1;
        end
        out_ready_i = 1'b0;
        @(negedge clk);
        chk("t2_popped", 64'(got), 64'(18));
        chk("t2_oval", 64'(out_valid_o), 64'(0));
        chk("t2_usedw", 64'(usedw_o), 64'(0));

        // 3: streaming, one word per cycle once the first word arrives
        sent = 0; got = 0; started = 1'b0;
        @(posedge clk); #1 out_ready_i = 1'b1; in_valid_i = 1'b1; in_data_i = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            if (in_valid_i) chk("t3_ready", 64'(in_ready_o), 64'(1));
            if (in_valid_i && in_ready_o) sent++;
            if (out_valid_o) begin
                started = 1'b1;
                chk("t3_data", 64'(out_data_o), 64'(got));
                got++;
            end else if (started && got < 100) begin
                chk("t3_gap", 64'(out_valid_o), 64'(1));
            end
            if (got == 100) break;
            @(posedge clk); #1 in_valid_i = (sent < 100); in_data_i = 32'(sent);
        end
        chk("t3_count", 64'(got), 64'(100));
        @(posedge clk); #1 in_valid_i = 1'b0; out_ready_i = 1'b0;

        // 4: random handshakes, reference model checks every word
        sent = 0; base = npop;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            @(posedge clk); #1;
            in_valid_i  = ($urandom % 2 == 0) && (sent < 1000);
            in_data_i   = 32'($urandom);
            out_ready_i = ($urandom % 2 == 0);
            @(negedge clk);
            if (in_valid_i && in_ready_o) sent++;
            if (npop - base >= 1000) break;
        end
        @(posedge clk); #1 in_valid_i = 1'b0; out_ready_i = 1'b0;
        chk("t4_words", 64'(npop - base), 64'(1000));

        // 5: flush with 7 held and a read in flight
        sent = 0;
        in_valid_i = 1'b1; in_data_i = 32'h500;
        for (int cyc = 0; cyc < 40 && sent < 9; cyc++) begin
            @(negedge clk);
            if (in_valid_i && in_ready_o) sent++;
            @(posedge clk); #1 in_data_i = 32'h500 + 32'(sent); in_valid_i = (sent < 9);
        end
        in_valid_i = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("t5_usedw9", 64'(usedw_o), 64'(9));
        @(posedge clk); #1 out_ready_i = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1 out_ready_i = 1'b0; flush_i = 1'b1;
        @(negedge clk);
        chk("t5_held", 64'(usedw_o), 64'(7));
        @(posedge clk); #1 flush_i = 1'b0;
        @(negedge clk);
        chk("t5_usedw0", 64'(usedw_o), 64'(0));
        chk("t5_oval0", 64'(out_valid_o), 64'(0));
        @(posedge clk); #1 in_valid_i = 1'b1; in_data_i = 32'hA5;
        @(posedge clk); #1 in_valid_i = 1'b0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            if (out_valid_o) break;
        end
        chk("t5_first_valid", 64'(out_valid_o), 64'(1));
        chk("t5_first_data", 64'(out_data_o), 64'(32'hA5));
        @(posedge clk); #1 out_ready_i = 1'b1;
        @(posedge clk); #1 out_ready_i = 1'b0;

        // 6: asynchronous reset mid-stream with 9 words held
        sent = 0;
        in_valid_i = 1'b1; in_data_i = 32'h600;
        for (int cyc = 0; cyc < 40 && sent < 9; cyc++) begin
            @(negedge clk);
            if (in_valid_i && in_ready_o) sent++;
            @(posedge clk); #1 in_data_i = 32'h600 + 32'(sent); in_valid_i = (sent < 9);
        end
        in_valid_i = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("t6_usedw9", 64'(usedw_o), 64'(9));
        @(posedge clk); #1 in_valid_i = 1'b1; in_data_i = 32'h77; out_ready_i = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("t6_oval", 64'(out_valid_o), 64'(0));
        chk("t6_cena", 64'(cena_o), 64'(1));
        chk("t6_cenb", 64'(cenb_o), 64'(1));
        @(posedge clk); #1 in_valid_i = 1'b0; out_ready_i = 1'b0;
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("t6_usedw0", 64'(usedw_o), 64'(0));
        chk("t6_ready", 64'(in_ready_o), 64'(1));
        chk("t6_oval_after", 64'(out_valid_o), 64'(0));

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
